// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared widths, depth and word/address types for memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage
`default_nettype wire

// File: rtl/step_edge.sv
`default_nettype none
// ============================================================================
// Module      : step_edge
// Description : One-flop rising-edge detector for a clk-synchronous strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module step_edge (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic r_in_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    // Clearing the history flop on reset makes a strobe already high at release look like an edge.
    assign pulse = in & ~r_in_q;
endmodule
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
// Module      : memory
// Description : 64 x 16 register-file memory, step-qualified writes and a
//               registered read-first read port.
// Revision    : 1.0 - initial release
// ============================================================================
module memory
    import mem_pkg::*;
#(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int ADDR_W = mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              step,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_dout;
    logic              w_step_pulse;

    step_edge u_step_edge (
        .clk   (clk),
        .reset (reset),
        .in    (step),
        .pulse (w_step_pulse)
    );

    // Read samples the array before the write lands, giving read-first behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_dout <= r_mem[address];
            if (w_step_pulse && write) begin
                r_mem[address] <= din;
            end
        end
    end

    assign dout = r_dout;
endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory
// Description : Directed self-checking bench for memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory;
    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic        step;
    logic [5:0]  address;
    logic [15:0] din;
    logic [15:0] dout;

    int n_cmp  = 0;
    int n_fail = 0;

    memory dut (
        .clk     (clk),
        .reset   (reset),
        .write   (write),
        .step    (step),
        .address (address),
        .din     (din),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; step = 1'b0; address = '0; din = '0;
        tick();

        // 1: reset sweep
        for (int a = 0; a < 64; a++) begin
            address = 6'(a);
            tick();
            check($sformatf("reset_sweep[%0d]", a), dout, 16'h0000);
        end
        reset = 1'b0;
        address = 6'd0;
        tick();
        check("after_release", dout, 16'h0000);

        // 2: basic write, read-first on the write edge
        address = 6'd5; din = 16'hA5A5; write = 1'b1; step = 1'b1;
        tick();
        check("wr5_old", dout, 16'h0000);
        step = 1'b0; write = 1'b0;
        tick();
        check("wr5_new", dout, 16'hA5A5);

        // 3: held step sweeping address; only address 0 written
        write = 1'b1; din = 16'h1234; step = 1'b1;
        for (int a = 0; a < 64; a++) begin
            address = 6'(a);
            tick();
        end
        step = 1'b0; write = 1'b0;
        for (int a = 0; a < 64; a++) begin
            address = 6'(a);
            tick();
            check($sformatf("held_sweep[%0d]", a), dout,
                  (a == 0) ? 16'h1234 : (a == 5) ? 16'hA5A5 : 16'h0000);
        end

        // 4: write gated off
        address = 6'd7; din = 16'hFFFF; write = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("gated7", dout, 16'h0000);

        // 5: top and bottom addresses with read-first
        address = 6'd63; din = 16'hBEEF; write = 1'b1; step = 1'b1;
        tick();
        check("wr63_old", dout, 16'h0000);
        step = 1'b0; write = 1'b0;
        tick();
        check("wr63_new", dout, 16'hBEEF);
        address = 6'd0; din = 16'h0001; write = 1'b1; step = 1'b1;
        tick();
        check("wr0_old", dout, 16'h1234);
        step = 1'b0; write = 1'b0;
        tick();
        check("wr0_new", dout, 16'h0001);
        address = 6'd63;
        tick();
        check("rd63", dout, 16'hBEEF);

        // 6: asynchronous reset between edges
        #2 reset = 1'b1;
        #1 check("async_dout", dout, 16'h0000);
        address = 6'd9; din = 16'h5555; write = 1'b1; step = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("release_no_step", dout, 16'h0000);
        write = 1'b0;
        for (int a = 0; a < 64; a++) begin
            address = 6'(a);
            tick();
            check($sformatf("post_reset[%0d]", a), dout, 16'h0000);
        end

        // step already high at release counts as an edge
        reset = 1'b1;
        address = 6'd10; din = 16'hCAFE; write = 1'b1; step = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("rel_step_old", dout, 16'h0000);
        tick();
        check("rel_step_new", dout, 16'hCAFE);
        din = 16'h0BAD; address = 6'd11;
        tick();
        check("held_no_rewrite11", dout, 16'h0000);
        step = 1'b0; write = 1'b0; address = 6'd10;
        tick();
        check("rd10", dout, 16'hCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
